// File: rtl/stack_pointer_unit.sv
// Empty-descending stack pointer with push/pop/load, combinational memory strobes
// and sticky overflow/underflow guards on the stack region [SP_LIMIT, SP_RESET].
module stack_pointer_unit #(
  parameter int unsigned           WIDTH    = 16,
  parameter logic [WIDTH-1:0]      SP_RESET = 16'hFFFF,
  parameter logic [WIDTH-1:0]      SP_LIMIT = 16'hFF00,
  parameter logic [WIDTH-1:0]      STEP     = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic [WIDTH-1:0] new_val,
  input  logic             clr_fault,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic             mem_re,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] EMPTY_TH = SP_RESET - STEP;

  logic [WIDTH-1:0] sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             we_raw, re_raw;

  assign full  = sp_q < SP_LIMIT;
  assign empty = sp_q > EMPTY_TH;

  always_comb begin
    sp_d     = sp_q;
    ovf_d    = ovf_q & ~clr_fault;
    udf_d    = udf_q & ~clr_fault;
    mem_addr = sp_q;
    we_raw   = 1'b0;
    re_raw   = 1'b0;
    if (load) begin
      sp_d = new_val;
    end else if (push && pop) begin
      sp_d = sp_q;
    end else if (push) begin
      if (!full) begin
        we_raw = 1'b1;
        sp_d   = sp_q - STEP;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      // SP points at the free slot, so the top entry lives one step above it
      if (!empty) begin
        re_raw   = 1'b1;
        mem_addr = sp_q + STEP;
        sp_d     = sp_q + STEP;
      end else begin
        udf_d = 1'b1;
      end
    end
  end

  // A reset cycle discards the request, including its memory access
  assign mem_we = we_raw & ~reset;
  assign mem_re = re_raw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= SP_RESET;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign out       = sp_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Randomized + directed bench for stack_pointer_unit; checks a STEP=1 and a
// STEP=2 instance against an arithmetic model of the stack rules.
module tb_stack_pointer_unit;

  localparam int RST = 'hFFFF;
  localparam int LIM = 'hFF00;

  logic        clk = 1'b0;
  logic        reset, push, pop, load, clr_fault;
  logic [15:0] new_val;

  logic [15:0] out_s [2];
  logic [15:0] addr_s[2];
  logic        we_s[2], re_s[2], full_s[2], empty_s[2], ovf_s[2], udf_s[2];

  int tests = 0;
  int errs  = 0;

  int  m_sp[2];
  bit  m_ovf[2], m_udf[2];
  bit  m_valid = 1'b0;

  always #5 clk = ~clk;

  stack_pointer_unit #(.WIDTH(16), .SP_RESET(16'hFFFF), .SP_LIMIT(16'hFF00), .STEP(16'd1)) u_dut1 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .load(load), .new_val(new_val),
    .clr_fault(clr_fault), .out(out_s[0]), .mem_addr(addr_s[0]), .mem_we(we_s[0]),
    .mem_re(re_s[0]), .full(full_s[0]), .empty(empty_s[0]), .overflow(ovf_s[0]),
    .underflow(udf_s[0]));

  stack_pointer_unit #(.WIDTH(16), .SP_RESET(16'hFFFF), .SP_LIMIT(16'hFF00), .STEP(16'd2)) u_dut2 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .load(load), .new_val(new_val),
    .clr_fault(clr_fault), .out(out_s[1]), .mem_addr(addr_s[1]), .mem_we(we_s[1]),
    .mem_re(re_s[1]), .full(full_s[1]), .empty(empty_s[1]), .overflow(ovf_s[1]),
    .underflow(udf_s[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, check outputs, then
  // advance the model on the rising edge.
  task automatic cyc(input bit r, input bit p, input bit q, input bit l,
                     input logic [15:0] v, input bit c);
    int  s, nsp, addr;
    bit  f, e, we, re, novf, nudf;
    @(negedge clk);
    reset = r; push = p; pop = q; load = l; new_val = v; clr_fault = c;
    #1;
    for (int i = 0; i < 2; i++) begin
      s    = (i == 0) ? 1 : 2;
      f    = m_sp[i] < LIM;
      e    = m_sp[i] > RST - s;
      nsp  = m_sp[i];
      addr = m_sp[i];
      we   = 1'b0;
      re   = 1'b0;
      novf = m_ovf[i] && !c;
      nudf = m_udf[i] && !c;
      if (r) begin
        nsp = RST; novf = 1'b0; nudf = 1'b0;
      end else if (l) begin
        nsp = int'(v);
      end else if (p && q) begin
        nsp = m_sp[i];
      end else if (p) begin
        if (!f) begin we = 1'b1; nsp = (m_sp[i] - s) & 'hFFFF; end
        else novf = 1'b1;
      end else if (q) begin
        if (!e) begin re = 1'b1; addr = (m_sp[i] + s) & 'hFFFF; nsp = addr; end
        else nudf = 1'b1;
      end
      if (m_valid) begin
        chk($sformatf("out%0d", i),   32'(out_s[i]),   32'(m_sp[i]));
        chk($sformatf("full%0d", i),  32'(full_s[i]),  32'(f));
        chk($sformatf("empty%0d", i), 32'(empty_s[i]), 32'(e));
        chk($sformatf("ovf%0d", i),   32'(ovf_s[i]),   32'(m_ovf[i]));
        chk($sformatf("udf%0d", i),   32'(udf_s[i]),   32'(m_udf[i]));
        chk($sformatf("we%0d", i),    32'(we_s[i]),    32'(we));
        chk($sformatf("re%0d", i),    32'(re_s[i]),    32'(re));
        if (!r) chk($sformatf("addr%0d", i), 32'(addr_s[i]), 32'(addr));
      end
      m_sp[i]  = nsp;
      m_ovf[i] = novf;
      m_udf[i] = nudf;
    end
    if (r) m_valid = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int k;
    logic [15:0] v;
    reset = 1'b0; push = 1'b0; pop = 1'b0; load = 1'b0; new_val = '0; clr_fault = 1'b0;

    // directed scenarios
    cyc(1, 0, 0, 0, 16'h0, 0);     // reset
    cyc(0, 0, 0, 0, 16'h0, 0);     // reset state visible
    cyc(0, 1, 0, 0, 16'h0, 0);     // push from FFFF
    cyc(0, 0, 1, 0, 16'h0, 0);     // pop back
    cyc(0, 0, 1, 0, 16'h0, 0);     // pop on empty -> underflow
    cyc(0, 0, 0, 0, 16'h0, 1);     // clr_fault
    cyc(0, 0, 0, 1, 16'hFF00, 0);  // load limit
    cyc(0, 1, 0, 0, 16'h0, 0);     // push at limit accepted
    cyc(0, 1, 0, 0, 16'h0, 0);     // push when full -> overflow
    cyc(0, 1, 0, 0, 16'h0, 1);     // clr_fault loses to new fault
    cyc(0, 1, 1, 0, 16'h0, 0);     // push&pop no-op
    cyc(0, 1, 0, 1, 16'hFFF0, 0);  // load beats push
    cyc(0, 1, 0, 0, 16'h0, 0);     // reset+push below
    cyc(1, 1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 1, 16'h0010, 0);  // load far outside region
    cyc(0, 0, 1, 0, 16'h0, 0);
    cyc(0, 0, 0, 0, 16'h0, 0);

    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: v = 16'hFFFF - 16'($urandom_range(0, 3));
        1: v = 16'hFF00 + 16'($urandom_range(0, 3)) - 16'd2;
        2: v = 16'($urandom_range(16'hFEF0, 16'hFFFF));
        default: v = 16'($urandom);
      endcase
      cyc(k < 2, (k >= 10 && k < 55) || k == 99, (k >= 55 && k < 95) || k == 99,
          k >= 2 && k < 10, v, $urandom_range(0, 9) == 0);
    end
    cyc(0, 0, 0, 0, 16'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
